// File: rtl/fifo_tx.sv
// Transmit-side byte FIFO between the UART data register and the serializer.
// Registered level and pop data, with sticky overflow/underflow flags for debug.
module fifo_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned CNT_WIDTH  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_push_en,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_full,
  output logic [CNT_WIDTH-1:0]  o_count,
  input  logic                  i_pop_en,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_pop_valid,
  output logic                  o_empty,
  input  logic                  i_flags_clr,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic pop_ok;
  logic push_ok;

  assign o_full  = (count_q == CNT_WIDTH'(DEPTH));
  assign o_empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is fine with a pop.
  assign pop_ok  = i_pop_en && !o_empty;
  assign push_ok = i_push_en && (!o_full || pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    overflow_d  = i_flags_clr ? 1'b0 : overflow_q;
    underflow_d = i_flags_clr ? 1'b0 : underflow_q;

    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d    = rd_ptr_q + PtrW'(1);
        pop_data_d  = mem[rd_ptr_q];
        pop_valid_d = 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
      // Set wins over a same-cycle clear request.
      if (i_push_en && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (i_pop_en && o_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset or flush is active.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_clear && push_ok) begin
      mem[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_count     = count_q;
  assign o_pop_data  = pop_data_q;
  assign o_pop_valid = pop_valid_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_fifo_tx.sv
// Directed, table-driven bench for fifo_tx at DEPTH=4; each row is one clock with
// the expected registered outputs just after that edge.
module tb_fifo_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop_en = 1'b0;
  logic          flags_clr = 1'b0;
  logic          full, pop_valid, empty, overflow, underflow;
  logic [CW-1:0] count;
  logic [DW-1:0] pop_data;

  int n_checks = 0;
  int n_fails  = 0;

  fifo_tx #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (clr),
    .i_push_en  (push_en),
    .i_push_data(push_data),
    .o_full     (full),
    .o_count    (count),
    .i_pop_en   (pop_en),
    .o_pop_data (pop_data),
    .o_pop_valid(pop_valid),
    .o_empty    (empty),
    .i_flags_clr(flags_clr),
    .o_overflow (overflow),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    bit            rst;
    bit            clr;
    bit            push;
    logic [DW-1:0] din;
    bit            pop;
    bit            fclr;
    logic [CW-1:0] cnt;
    bit            full;
    bit            empty;
    bit            pv;
    logic [DW-1:0] pd;
    bit            ov;
    bit            un;
  } vec_t;

  vec_t vecs[$];

  task automatic apply(input vec_t v);
    logic [15:0] got, exp;
    rst       = v.rst;
    clr       = v.clr;
    push_en   = v.push;
    push_data = v.din;
    pop_en    = v.pop;
    flags_clr = v.fclr;
    @(posedge clk);
    #1;
    got = {count, full, empty, pop_valid, pop_data, overflow, underflow};
    exp = {v.cnt, v.full, v.empty, v.pv, v.pd, v.ov, v.un};
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got cnt=%0d full=%b empty=%b pv=%b pd=%h ov=%b un=%b, required cnt=%0d full=%b empty=%b pv=%b pd=%h ov=%b un=%b",
               v.name, count, full, empty, pop_valid, pop_data, overflow, underflow,
               v.cnt, v.full, v.empty, v.pv, v.pd, v.ov, v.un);
    end
  endtask

  task automatic add(input string name, input bit r, input bit c, input bit pu,
                     input logic [DW-1:0] d, input bit po, input bit fc,
                     input logic [CW-1:0] cnt, input bit fu, input bit em, input bit pv,
                     input logic [DW-1:0] pd, input bit ov, input bit un);
    vec_t v;
    v.name = name; v.rst = r; v.clr = c; v.push = pu; v.din = d; v.pop = po; v.fclr = fc;
    v.cnt = cnt; v.full = fu; v.empty = em; v.pv = pv; v.pd = pd; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endtask

  initial begin
    //   name           rst clr psh din    pop fcl  cnt full emp pv pd     ov un
    add("reset",        1,  0,  0,  8'h00, 0,  0,   0,  0,   1,  0, 8'h00, 0, 0);
    add("t1_push11",    0,  0,  1,  8'h11, 0,  0,   1,  0,   0,  0, 8'h00, 0, 0);
    add("t1_push22",    0,  0,  1,  8'h22, 0,  0,   2,  0,   0,  0, 8'h00, 0, 0);
    add("t1_push33",    0,  0,  1,  8'h33, 0,  0,   3,  0,   0,  0, 8'h00, 0, 0);
    add("t1_push44",    0,  0,  1,  8'h44, 0,  0,   4,  1,   0,  0, 8'h00, 0, 0);
    add("t2_push_full", 0,  0,  1,  8'h55, 0,  0,   4,  1,   0,  0, 8'h00, 1, 0);
    add("t2_pop11",     0,  0,  0,  8'h00, 1,  0,   3,  0,   0,  1, 8'h11, 1, 0);
    add("t2_pop22",     0,  0,  0,  8'h00, 1,  0,   2,  0,   0,  1, 8'h22, 1, 0);
    add("t2_pop33",     0,  0,  0,  8'h00, 1,  0,   1,  0,   0,  1, 8'h33, 1, 0);
    add("t2_pop44",     0,  0,  0,  8'h00, 1,  0,   0,  0,   1,  1, 8'h44, 1, 0);
    add("t2_idle_hold", 0,  0,  0,  8'h00, 0,  0,   0,  0,   1,  0, 8'h44, 1, 0);
    add("t3_fill1",     0,  0,  1,  8'h11, 0,  0,   1,  0,   0,  0, 8'h44, 1, 0);
    add("t3_fill2",     0,  0,  1,  8'h22, 0,  0,   2,  0,   0,  0, 8'h44, 1, 0);
    add("t3_fill3",     0,  0,  1,  8'h33, 0,  0,   3,  0,   0,  0, 8'h44, 1, 0);
    add("t3_fill4",     0,  0,  1,  8'h44, 0,  0,   4,  1,   0,  0, 8'h44, 1, 0);
    add("t3_pushpop",   0,  0,  1,  8'h66, 1,  0,   4,  1,   0,  1, 8'h11, 1, 0);
    add("t3_pop22",     0,  0,  0,  8'h00, 1,  0,   3,  0,   0,  1, 8'h22, 1, 0);
    add("t3_pop33",     0,  0,  0,  8'h00, 1,  0,   2,  0,   0,  1, 8'h33, 1, 0);
    add("t3_pop44",     0,  0,  0,  8'h00, 1,  0,   1,  0,   0,  1, 8'h44, 1, 0);
    add("t3_pop66",     0,  0,  0,  8'h00, 1,  0,   0,  0,   1,  1, 8'h66, 1, 0);
    add("t4_pushpop_e", 0,  0,  1,  8'hA5, 1,  0,   1,  0,   0,  0, 8'h66, 1, 1);
    add("t4_popA5",     0,  0,  0,  8'h00, 1,  0,   0,  0,   1,  1, 8'hA5, 1, 1);
    add("t5_push01",    0,  0,  1,  8'h01, 0,  0,   1,  0,   0,  0, 8'hA5, 1, 1);
    add("t5_push02",    0,  0,  1,  8'h02, 0,  0,   2,  0,   0,  0, 8'hA5, 1, 1);
    add("t5_push03",    0,  0,  1,  8'h03, 0,  0,   3,  0,   0,  0, 8'hA5, 1, 1);
    add("t5_clear",     0,  1,  1,  8'h04, 1,  0,   0,  0,   1,  0, 8'hA5, 1, 1);
    add("t5_fclr_set",  0,  0,  0,  8'h00, 1,  1,   0,  0,   1,  0, 8'hA5, 0, 1);
    add("t5_fclr",      0,  0,  0,  8'h00, 0,  1,   0,  0,   1,  0, 8'hA5, 0, 0);
    add("t5_push07",    0,  0,  1,  8'h07, 0,  0,   1,  0,   0,  0, 8'hA5, 0, 0);
    add("t5_pop07",     0,  0,  0,  8'h00, 1,  0,   0,  0,   1,  1, 8'h07, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Reset mid-operation: raise both flags, leave an entry queued, then reset with a pop.
    begin
      vec_t v;
      v = '{"t6_underflow", 0, 0, 0, 8'h00, 1, 0, 3'd0, 0, 1, 0, 8'h07, 0, 1};
      apply(v);
      for (int i = 0; i < 5; i++) begin
        v.name  = $sformatf("t6_push%0d", i);
        v.pop   = 0;
        v.push  = 1;
        v.din   = DW'(8'hC0 + i);
        v.cnt   = (i < 4) ? CW'(i + 1) : CW'(4);
        v.full  = (i >= 3);
        v.empty = 0;
        v.ov    = (i == 4);
        apply(v);
      end
      v = '{"t6_rst_pop", 1, 0, 0, 8'h00, 1, 0, 3'd0, 0, 1, 0, 8'h00, 0, 0};
      apply(v);
      v = '{"t6_after_rst", 0, 0, 0, 8'h00, 0, 0, 3'd0, 0, 1, 0, 8'h00, 0, 0};
      apply(v);
      v = '{"t6_pop_empty", 0, 0, 0, 8'h00, 1, 0, 3'd0, 0, 1, 0, 8'h00, 0, 1};
      apply(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
